// File: rtl/seq_rec_pkg.sv
// Shared constants for the parametrised serial sequence recognizer.
//   LEN_MIN / LEN_MAX : legal range of the pattern length parameter
//   OVERLAP_ON / OFF  : encodings of the run-time overlap select input
package seq_rec_pkg;
    localparam int   LEN_MIN     = 2;
    localparam int   LEN_MAX     = 16;
    localparam logic OVERLAP_ON  = 1'b1;
    localparam logic OVERLAP_OFF = 1'b0;
endpackage

// File: rtl/seq_recognizer_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, forces q to zero
//   clr   : synchronous clear, has priority over inc
//   inc   : increment request, ignored once q is all-ones
//   q     : count value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_recognizer_param.sv
// Parametrised serial sequence recognizer.
// Detects the LEN-bit PATTERN on serial input x (PATTERN[LEN-1] arrives first).
// Ports:
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset
//   en          : sample enable, x is consumed only when en=1
//   x           : serial data bit
//   overlap     : 1 = overlapping matches allowed, 0 = non-overlapping
//   count_clr   : synchronous clear of match_count (beats a simultaneous match)
//   z           : combinational Mealy match flag
//   z_q         : z delayed by one clock
//   match_count : saturating number of matches
module seq_recognizer_param
    import seq_rec_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1101,
    parameter int             CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             count_clr,
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_count
);

    if ((LEN < LEN_MIN) || (LEN > LEN_MAX)) begin : g_bad_len
        $error("seq_recognizer_param: LEN must be within 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("seq_recognizer_param: CNT_W must be at least 1");
    end

    localparam int                FILL_W    = $clog2(LEN) + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN - 1);

    logic [LEN-2:0]    hist;
    logic [FILL_W-1:0] fill;
    logic [LEN-1:0]    window;

    // Candidate window: the LEN-1 stored bits followed by the bit on x now.
    // Its low LEN-1 bits are also the next history, which covers LEN=2 too.
    assign window = {hist, x};

    // fill reaching LEN-1 means every history bit came after the last reset
    // or non-overlapping match, so a stale or consumed bit can never match.
    assign z = en & (fill == FILL_FULL) & (window == PATTERN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
            z_q  <= 1'b0;
        end else begin
            z_q <= z;
            if (en) begin
                hist <= window[LEN-2:0];
                if (z && (overlap == OVERLAP_OFF)) begin
                    fill <= '0;
                end else if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_count (
        .clock (clock),
        .reset (reset),
        .clr   (count_clr),
        .inc   (z),
        .q     (match_count)
    );

endmodule

// File: tb/tb_seq_recognizer_param.sv
module tb_seq_recognizer_param;

    localparam int LEN = 4;
    localparam int PAT = 13;   // 4'b1101
    localparam int MAX1 = 255; // CNT_W = 8
    localparam int MAX2 = 3;   // CNT_W = 2

    logic       clock;
    logic       reset;
    logic       en;
    logic       x;
    logic       overlap;
    logic       count_clr;
    logic       z, z_q, z2, z_q2;
    logic [7:0] match_count;
    logic [1:0] match_count2;

    int total = 0;
    int bad   = 0;
    int prev_ez = 0;

    seq_recognizer_param #(.LEN(4), .PATTERN(4'b1101), .CNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .x           (x),
        .overlap     (overlap),
        .count_clr   (count_clr),
        .z           (z),
        .z_q         (z_q),
        .match_count (match_count)
    );

    seq_recognizer_param #(.LEN(4), .PATTERN(4'b1101), .CNT_W(2)) dut2 (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .x           (x),
        .overlap     (overlap),
        .count_clr   (count_clr),
        .z           (z2),
        .z_q         (z_q2),
        .match_count (match_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hq holds the bits accepted since the last reset or non-overlapping match
    // (only the most recent LEN-1 are kept).
    int hq[$];
    int mzq, mcnt, mcnt2;
    bit mz_edge;

    function automatic bit model_z(bit e, bit xv);
        int v;
        if (!e || hq.size() < LEN - 1) return 1'b0;
        v = 0;
        for (int i = hq.size() - (LEN - 1); i < hq.size(); i++) v = (v << 1) | hq[i];
        v = (v << 1) | int'(xv);
        return v == PAT;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            hq.delete();
            mzq   = 0;
            mcnt  = 0;
            mcnt2 = 0;
        end else begin
            mz_edge = model_z(en, x);
            mzq = int'(mz_edge);
            if (count_clr) begin
                mcnt  = 0;
                mcnt2 = 0;
            end else if (mz_edge) begin
                if (mcnt  < MAX1) mcnt++;
                if (mcnt2 < MAX2) mcnt2++;
            end
            if (en) begin
                if (mz_edge && !overlap) begin
                    hq.delete();
                end else begin
                    hq.push_back(int'(x));
                    if (hq.size() > LEN - 1) void'(hq.pop_front());
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("model_z",     int'(z),            int'(model_z(en, x)));
        chk("model_z2",    int'(z2),           int'(model_z(en, x)));
        chk("model_zq",    int'(z_q),          mzq);
        chk("model_zq2",   int'(z_q2),         mzq);
        chk("model_cnt",   int'(match_count),  mcnt);
        chk("model_cnt2",  int'(match_count2), mcnt2);
    end

    // ---------------- directed helpers ----------------
    task automatic drive(input bit e, input bit xv, input bit ov, input bit clr, input int ez);
        en = e; x = xv; overlap = ov; count_clr = clr;
        #3;
        chk("dir_z", int'(z), ez);
        chk("dir_zq", int'(z_q), prev_ez);
        prev_ez = ez;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; count_clr = 1'b0;
        reset = 1'b0;
        #2;
        chk("rst_z", int'(z), 0);
        chk("rst_zq", int'(z_q), 0);
        chk("rst_cnt", int'(match_count), 0);
        chk("rst_cnt2", int'(match_count2), 0);
        #1;
        reset = 1'b1;
        prev_ez = 0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s1[7]   = '{1, 1, 0, 1, 1, 0, 1};
        int e1[7]   = '{0, 0, 0, 1, 0, 0, 1};
        int e2[7]   = '{0, 0, 0, 1, 0, 0, 0};
        bit s3b[5]  = '{1, 1, 1, 0, 1};
        int e3b[5]  = '{0, 0, 0, 0, 1};
        bit s5[13]  = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
        int c5b[4]  = '{1, 2, 3, 3};
        int k;

        reset = 1'b0; en = 1'b0; x = 1'b0; overlap = 1'b1; count_clr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // Test 1: overlapping detection
        do_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, s1[i], 1'b1, 1'b0, e1[i]);
        chk("t1_cnt", int'(match_count), 2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0);

        // Test 2: non-overlapping detection
        do_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, s1[i], 1'b0, 1'b0, e2[i]);
        chk("t2_cnt", int'(match_count), 1);

        // Test 3: reset mid-sequence discards the partial match
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0);
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, s3b[i], 1'b1, 1'b0, e3b[i]);
        chk("t3_cnt", int'(match_count), 1);

        // Test 4: enable gap before the final bit
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1);
        chk("t4_cnt", int'(match_count), 1);

        // Test 5: 2-bit counter saturates at 3
        do_reset();
        k = 0;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, s5[i], 1'b1, 1'b0, (i % 3 == 0 && i > 0) ? 1 : 0);
            if (i % 3 == 0 && i > 0) begin
                chk("t5_cnt2", int'(match_count2), c5b[k]);
                chk("t5_cnt", int'(match_count), k + 1);
                k++;
            end
        end

        // Test 6: clear wins over a simultaneous match
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1);
        chk("t6_cnt_clr", int'(match_count), 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1);
        chk("t6_cnt_next", int'(match_count), 1);

        // Randomised phase, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 9) < 8);
            x         = 1'($urandom_range(0, 1));
            count_clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) overlap = ~overlap;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                #2;
                reset = 1'b1;
            end
            @(posedge clock);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
